// File: rtl/gamepad_reader_pkg.sv
// Shared definitions for the serial gamepad poller: FSM states and frame timing.
package gamepad_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WAIT_LO,
    ST_CLK_HI,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_BUTTONS  = 8;
  localparam int unsigned LATCH_HALVES = 2;
  // LATCH (2) + eight pad_clk low phases (8) + seven high phases (7)
  localparam int unsigned FRAME_HALVES = 17;

  function automatic int unsigned frame_len(input int unsigned half);
    return FRAME_HALVES * half;
  endfunction

endpackage

// File: rtl/gamepad_reader_pad_sync.sv
// Two-flop synchroniser for an asynchronous pad input (pad_data, gun_data).
module pad_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {2{RESET_VAL}};
    else        sync_q <= {sync_q[0], async_i};
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/gamepad_reader.sv
// Polls a latch/clock/data game controller and presents an atomic 8-button
// snapshot to the core, raising a level interrupt when the snapshot changes.
module gamepad_reader
  import gamepad_reader_pkg::*;
#(
  parameter int unsigned HALF           = 300,
  parameter int unsigned POLL           = 400000,
  parameter bit          ACTIVE_LOW_PAD = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pad_data,
  input  logic                   poll_now,
  input  logic                   irq_ack,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [NUM_BUTTONS-1:0] controller_data,
  output logic                   frame_done,
  output logic                   irq_req
);

  localparam int unsigned PW = (POLL > 1) ? $clog2(POLL) : 1;
  localparam int unsigned TW = $clog2(LATCH_HALVES * HALF);

  state_e                 state_q, state_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] data_q, data_d;
  logic                   irq_q, irq_d;

  logic                   pad_s;
  logic                   poll_wrap;
  logic                   timer_last;
  logic [TW-1:0]          timer_lim;

  // Idle line is pulled high, so the synchroniser resets to "released".
  pad_sync #(.RESET_VAL(1'b1)) u_pad_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (pad_data),
    .sync_o  (pad_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      poll_q  <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    irq_d      = irq_q;

    poll_wrap  = (poll_q == PW'(POLL - 1));
    poll_d     = poll_wrap ? '0 : poll_q + PW'(1);

    timer_lim  = (state_q == ST_LATCH) ? TW'(LATCH_HALVES * HALF - 1) : TW'(HALF - 1);
    timer_last = (timer_q == timer_lim);

    if (irq_ack) irq_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (poll_wrap || poll_now) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        timer_d = timer_q + TW'(1);
        if (timer_last) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        timer_d = timer_q + TW'(1);
        if (timer_last) begin
          timer_d        = '0;
          shift_d[idx_q] = pad_s ^ ACTIVE_LOW_PAD;
          state_d        = (idx_q == 3'd7) ? ST_DONE : ST_CLK_HI;
        end
      end
      ST_CLK_HI: begin
        timer_d = timer_q + TW'(1);
        if (timer_last) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          state_d = ST_WAIT_LO;
        end
      end
      ST_DONE: begin
        // Set takes priority over a coincident acknowledge.
        data_d  = shift_q;
        if (shift_q != data_q) irq_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pad_latch       = (state_q == ST_LATCH);
  assign pad_clk         = (state_q == ST_CLK_HI);
  assign frame_done      = (state_q == ST_DONE);
  assign controller_data = data_q;
  assign irq_req         = irq_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Scoreboard bench for gamepad_reader with a behavioural controller model.
module tb_gamepad_reader;

  typedef struct {
    logic [7:0] data;
    logic       irq;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pad_data = 1'b1;
  logic       poll_now = 1'b0;
  logic       irq_ack = 1'b0;
  logic       pad_latch, pad_clk, frame_done, irq_req;
  logic [7:0] controller_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rel0 = 0;
  exp_t q[$];

  logic [7:0] pattern = 8'hFE;
  logic [7:0] m_data = 8'h00;
  logic       m_irq = 1'b0;

  gamepad_reader #(.HALF(4), .POLL(100), .ACTIVE_LOW_PAD(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .pad_data        (pad_data),
    .poll_now        (poll_now),
    .irq_ack         (irq_ack),
    .pad_latch       (pad_latch),
    .pad_clk         (pad_clk),
    .controller_data (controller_data),
    .frame_done      (frame_done),
    .irq_req         (irq_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Shift-register controller: latch loads bit0, each pad_clk rise advances.
  int   bitpos = 8;
  logic prev_pclk = 1'b0;
  always @(negedge clk) begin
    if (pad_latch) bitpos = 0;
    else if (pad_clk && !prev_pclk && bitpos < 8) bitpos = bitpos + 1;
    prev_pclk = pad_clk;
    pad_data  = (bitpos < 8) ? pattern[bitpos] : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected snapshot: pressed = inverted pad level; interrupt set on change.
  task automatic push_frame(input logic [7:0] pat, input bit ack_in_done);
    exp_t e;
    if (~pat != m_data) m_irq = 1'b1;
    else if (ack_in_done) m_irq = 1'b0;
    m_data = ~pat;
    e.data = m_data;
    e.irq  = m_irq;
    q.push_back(e);
  endtask

  task automatic ack_idle();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    m_irq   = 1'b0;
    check("irq_cleared_by_ack", {31'd0, irq_req}, 32'd0);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_done: got timeout expected pulse within %0d cycles", budget);
    end
  endtask

  task automatic wait_latch(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pad_latch === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_latch: got timeout expected rise within %0d cycles", budget);
    end
  endtask

  task automatic wait_clk_rises(input int n, input int budget);
    int   cnt  = 0;
    logic prev = 1'b0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      @(negedge clk);
      if (pad_clk && !prev) cnt++;
      prev = pad_clk;
    end
    if (cnt < n) begin
      checks++;
      errors++;
      $display("FAIL wait_pad_clk: got %0d rises expected %0d", cnt, n);
    end
  endtask

  // Monitor: every frame_done pops one expectation; snapshot is visible next cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame_done expected none");
        end else begin
          e = q.pop_front();
          @(negedge clk);
          check("controller_data", {24'd0, controller_data}, {24'd0, e.data});
          check("irq_req", {31'd0, irq_req}, {31'd0, e.irq});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   latch_len, pulses, badw, run, done_off, t0;
    logic prevclk;
    logic [7:0] pat;
    int   mode;

    // 1: reset values
    repeat (4) @(negedge clk);
    check("rst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_pad_clk", {31'd0, pad_clk}, 32'd0);
    check("rst_data", {24'd0, controller_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_irq", {31'd0, irq_req}, 32'd0);

    // 1+2: first frame at poll wrap, A pressed
    pattern = 8'hFE;
    push_frame(8'hFE, 1'b0);
    reset = 1'b1;
    rel0  = cyc;
    wait_latch(200);
    check("first_latch_cycle", cyc - rel0, 32'd100);
    latch_len = 0; pulses = 0; badw = 0; run = 0; done_off = -1; prevclk = 1'b0;
    for (int i = 0; i < 75; i++) begin
      if (i > 0) @(negedge clk);
      if (pad_latch) latch_len++;
      if (pad_clk) run++;
      else if (prevclk) begin
        pulses++;
        if (run != 4) badw++;
        run = 0;
      end
      prevclk = pad_clk;
      if (frame_done && done_off < 0) done_off = i;
    end
    check("latch_width", latch_len, 32'd8);
    check("pad_clk_pulses", pulses, 32'd7);
    check("pad_clk_bad_widths", badw, 32'd0);
    check("frame_done_offset", done_off, 32'd68);

    // 3: identical frame keeps irq; ack clears and a repeat does not re-set
    push_frame(8'hFE, 1'b0);
    wait_done(200);
    @(negedge clk);
    ack_idle();
    push_frame(8'hFE, 1'b0);
    wait_done(200);
    @(negedge clk);

    // 4: change with ack in the DONE cycle
    pattern = 8'h7F;
    push_frame(8'h7F, 1'b1);
    wait_done(200);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;

    // 5: poll_now starts a frame from IDLE; mid-frame requests and wraps are dropped
    ack_idle();
    pattern = 8'hF7;
    push_frame(8'hF7, 1'b0);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    check("poll_now_start", {31'd0, pad_latch}, 32'd1);
    t0 = cyc;
    wait_clk_rises(4, 80);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_done(200);
    check("poll_now_frame_len", cyc - t0, 32'd68);
    push_frame(8'hF7, 1'b0);
    wait_latch(200);
    check("next_latch_on_wrap", (cyc - rel0) % 100, 32'd0);
    wait_done(200);
    @(negedge clk);

    // random frames
    for (int f = 0; f < 12; f++) begin
      mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       pat = pattern;
        1:       pat = 8'hFF;
        default: pat = 8'($urandom);
      endcase
      if (f == 11) pat = 8'h3C;
      pattern = pat;
      if (mode == 1) ack_idle();
      push_frame(pat, mode == 2);
      wait_done(250);
      if (mode == 2) irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
    end

    // 6: reset during bit 4
    wait_latch(200);
    wait_clk_rises(4, 80);
    for (int i = 0; i < 10 && pad_clk; i++) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("midrst_pad_clk", {31'd0, pad_clk}, 32'd0);
    check("midrst_data", {24'd0, controller_data}, 32'd0);
    check("midrst_irq", {31'd0, irq_req}, 32'd0);
    m_data = 8'h00;
    m_irq  = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(8'h3C, 1'b0);
    reset = 1'b1;
    rel0  = cyc;
    wait_latch(200);
    check("post_reset_latch_cycle", cyc - rel0, 32'd100);
    wait_done(200);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
